// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART.
//   UART_ADDR    : base address of the UART register pair (002h/003h)
//   RX_HEAD      : upper byte returned with the received byte
//   STATUS_HEAD  : upper byte returned with the status word
//   uart_state_t : frame state shared by the TX and RX state machines
package uart_pkg;

  localparam logic [9:0] UART_ADDR   = 10'h002;
  localparam logic [7:0] RX_HEAD     = 8'hfe;
  localparam logic [7:0] STATUS_HEAD = 8'hfd;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU data-bus bundle seen by the UART responder.
//   mem_addr : CPU address
//   mem_wr   : one-cycle write strobe
//   wr_data  : write data (low byte is the TX byte)
//   rd_data  : registered read data
//   rd_sel   : registered "previous address hit this block"
// master = CPU side, slave = UART side.
interface uart_mmio_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr;
  logic [15:0]           wr_data;
  logic [15:0]           rd_data;
  logic                  rd_sel;

  modport master (output mem_addr, mem_wr, wr_data, input rd_data, rd_sel);
  modport slave  (input mem_addr, mem_wr, wr_data, output rd_data, rd_sel);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling.
//   clk, rst : system clock, asynchronous active-high reset
//   rx       : serial input, asynchronous to clk
//   data     : last shifted byte (valid when valid pulses)
//   valid    : one-cycle pulse, good stop bit seen
//   ferr     : one-cycle pulse, stop bit was 0 (byte discarded)
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta, rx_sync, rx_prev;
  uart_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  assign data = shift;

  // Synchroniser plus one extra flop so a falling edge needs the line to have
  // been high first; this also re-arms only after the line returns high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt   <= HALF_LAST;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            // A line back high at mid start bit is a glitch.
            if (!rx_sync) begin
              cnt     <= BIT_LAST;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= BIT_LAST;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_sync) valid <= 1'b1;
            else ferr <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART responder at 002h-003h on the CPU data bus.
// Writes push the low byte into a TX FIFO that is serialised 8N1 LSB first;
// reads return {fe, last received byte}.
// Optional build macro UART_MMIO_STATUS_EN: 003h returns
// {fd, 4'b0, rx_new, rx_ferr, tx_full, tx_empty}.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : uart_mmio_if.slave (mem_addr, mem_wr, wr_data, rd_data, rd_sel)
//   uart_tx  : registered serial output, idle high
//   uart_rx  : serial input
//   tx_busy  : FIFO non-empty or shifter active
module uart_mmio
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int CLKS_PER_BIT  = 217,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_mmio_if.slave  bus,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(UART_ADDR);

  logic        hit, push, pop, full, empty;
  logic [AW:0] wptr, rptr;
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [7:0]  head;

  uart_state_t tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  logic [7:0]  rx_byte, rx_data;
  logic        rx_valid, rx_ferr_pulse;
  logic [15:0] rd_word;

  assign hit   = bus.mem_addr[ADDR_WIDTH-1:1] == BASE[ADDR_WIDTH-1:1];
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = fifo_mem[rptr[AW-1:0]];
  // The shifter loads from IDLE or straight out of the last stop-bit cycle,
  // so queued bytes go out with no idle gap.
  assign pop   = !empty && ((tx_state == IDLE) || (tx_state == STOP && tx_cnt == '0));
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push  = bus.mem_wr && hit && (!full || pop);
  assign tx_busy = !empty || (tx_state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[AW-1:0]] <= bus.wr_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (pop) begin
            tx_shift <= head;
            tx_cnt   <= BIT_LAST;
            uart_tx  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == '0) begin
            if (pop) begin
              tx_shift <= head;
              tx_cnt   <= BIT_LAST;
              uart_tx  <= 1'b0;
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .rx    (uart_rx),
    .data  (rx_data),
    .valid (rx_valid),
    .ferr  (rx_ferr_pulse)
  );

`ifdef UART_MMIO_STATUS_EN
  logic rx_new, rx_ferr, cpu_read;

  assign cpu_read = hit && !bus.mem_wr;
  assign rd_word  = bus.mem_addr[0] ? {STATUS_HEAD, 4'b0, rx_new, rx_ferr, full, empty}
                                    : {RX_HEAD, rx_byte};

  // Setting beats clearing so a byte arriving during a read is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_new  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      if (rx_valid) rx_new <= 1'b1;
      else if (cpu_read && !bus.mem_addr[0]) rx_new <= 1'b0;
      if (rx_ferr_pulse) rx_ferr <= 1'b1;
      else if (cpu_read && bus.mem_addr[0]) rx_ferr <= 1'b0;
    end
  end
`else
  logic unused_status;

  assign rd_word       = {RX_HEAD, rx_byte};
  assign unused_status = &{1'b0, rx_ferr_pulse};
`endif

  // A read in the same cycle as an RX completion returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
      bus.rd_sel  <= 1'b0;
      rx_byte     <= '0;
    end else begin
      bus.rd_sel <= hit;
      if (hit) bus.rd_data <= rd_word;
      if (rx_valid) rx_byte <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with CLKS_PER_BIT=4 and an 8-entry TX FIFO.
// Expected TX bytes and read words are queued when stimulus is driven; a
// line monitor decodes uart_tx frames and pops/compares the TX queue.
module tb_uart_mmio;

  logic clk;
  logic rst;
  logic uart_tx;
  logic uart_rx;
  logic tx_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  tx_exp_q[$];
  logic [15:0] rd_q[$];
  int          starts_q[$];

  uart_mmio_if #(.ADDR_WIDTH(10)) bus ();

  uart_mmio #(
    .ADDR_WIDTH    (10),
    .CLKS_PER_BIT  (4),
    .TX_FIFO_DEPTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx),
    .tx_busy (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    bus.mem_addr = a;
    bus.mem_wr   = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.mem_wr   = 1'b0;
    bus.mem_addr = '0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] exp, input string tag);
    rd_q.push_back(exp);
    bus.mem_addr = a;
    bus.mem_wr   = 1'b0;
    tick();
    bus.mem_addr = '0;
    chk({tag, "_sel"}, 16'(bus.rd_sel), 16'd1);
    chk(tag, bus.rd_data, rd_q.pop_front());
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) tick();
    end
    uart_rx = stop_bit;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (6) tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((tx_busy || tx_exp_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    chk({tag, "_in_time"}, 16'(n < 1000), 16'd1);
    chk({tag, "_queue_empty"}, 16'(tx_exp_q.size()), 16'd0);
  endtask

  // TX line monitor: start detected at offset 0, samples at offsets 2+4j.
  initial begin : tx_mon
    logic [9:0] smp;
    logic       aborted;
    logic       avail;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        smp = '0;
        aborted = 1'b0;
        starts_q.push_back(cyc);
        for (int k = 1; k <= 38; k++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if ((k % 4) == 2) smp[k / 4] = uart_tx;
        end
        if (!aborted) begin
          chk("tx_start_bit", 16'(smp[0]), 16'd0);
          chk("tx_stop_bit", 16'(smp[9]), 16'd1);
          avail = tx_exp_q.size() != 0;
          chk("tx_frame_expected", 16'(avail), 16'd1);
          if (avail) chk("tx_byte", 16'(smp[8:1]), 16'(tx_exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : main
    int n;
    int n_starts;
    rst          = 1'b1;
    uart_rx      = 1'b1;
    bus.mem_addr = '0;
    bus.mem_wr   = 1'b0;
    bus.wr_data  = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();

    // Reset / idle state
    chk("reset_uart_tx", 16'(uart_tx), 16'd1);
    chk("reset_tx_busy", 16'(tx_busy), 16'd0);
    chk("reset_rd_data", bus.rd_data, 16'h0000);
    chk("reset_rd_sel", 16'(bus.rd_sel), 16'd0);

    // Accesses outside 002h-003h
    bus.mem_addr = 10'h004;
    tick();
    bus.mem_addr = '0;
    chk("nohit_rd_sel", 16'(bus.rd_sel), 16'd0);
    wr(10'h004, 16'h0055);
    tick();
    chk("nohit_write_busy", 16'(tx_busy), 16'd0);

    // Single frame of 41h and its length
    tx_exp_q.push_back(8'h41);
    wr(10'h002, 16'h1241);
    chk("tx41_busy", 16'(tx_busy), 16'd1);
    n = 0;
    while (tx_busy && n < 200) begin
      tick();
      n++;
    end
    chk("tx41_busy_cycles", 16'(n), 16'd41);
    chk("tx41_queue_empty", 16'(tx_exp_q.size()), 16'd0);

    // Nine consecutive writes fill the FIFO; a tenth is dropped
    starts_q.delete();
    for (int i = 1; i <= 9; i++) begin
      tx_exp_q.push_back(8'(i));
      bus.mem_addr = 10'h003;
      bus.mem_wr   = 1'b1;
      bus.wr_data  = 16'(i);
      tick();
    end
    bus.wr_data = 16'h00aa;
    tick();
    bus.mem_wr   = 1'b0;
    bus.mem_addr = '0;
`ifdef UART_MMIO_STATUS_EN
    rd(10'h003, 16'hfd02, "status_full");
`endif
    drain("b2b");
    chk("b2b_frames", 16'(starts_q.size()), 16'd9);
    for (int i = 1; i < 9 && i < starts_q.size(); i++)
      chk("b2b_gap", 16'(starts_q[i] - starts_q[i-1]), 16'd40);

    // RX of a good byte, repeated reads
    send_rx(8'h5a, 1'b1);
`ifdef UART_MMIO_STATUS_EN
    rd(10'h003, 16'hfd09, "status_rx_new");
    rd(10'h002, 16'hfe5a, "rx_5a_first");
    rd(10'h003, 16'hfd01, "status_new_cleared");
`else
    rd(10'h002, 16'hfe5a, "rx_5a_first");
    rd(10'h003, 16'hfe5a, "rx_5a_alias");
`endif
    rd(10'h002, 16'hfe5a, "rx_5a_second");

    // Framing error keeps the old byte
    send_rx(8'h33, 1'b0);
`ifdef UART_MMIO_STATUS_EN
    rd(10'h003, 16'hfd03, "status_ferr_set");
    rd(10'h003, 16'hfd01, "status_ferr_cleared");
`endif
    rd(10'h002, 16'hfe5a, "rx_after_ferr");

    // One-cycle glitch on an idle line
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    rd(10'h002, 16'hfe5a, "rx_after_glitch");
`ifdef UART_MMIO_STATUS_EN
    rd(10'h003, 16'hfd01, "status_after_glitch");
`endif

    // Another pattern
    send_rx(8'ha5, 1'b1);
    rd(10'h002, 16'hfea5, "rx_a5");

    // Reset in the middle of a TX frame
    tx_exp_q.push_back(8'h77);
    wr(10'h002, 16'h0077);
    repeat (15) tick();
    rst = 1'b1;
    #1;
    chk("rst_uart_tx", 16'(uart_tx), 16'd1);
    chk("rst_tx_busy", 16'(tx_busy), 16'd0);
    tx_exp_q.delete();
    n_starts = starts_q.size();
    tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("rst_no_frames", 16'(starts_q.size()), 16'(n_starts));
    chk("rst_busy_after", 16'(tx_busy), 16'd0);
    chk("rst_line_idle", 16'(uart_tx), 16'd1);
    rd(10'h002, 16'hfe00, "rst_rx_cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
